// File: rtl/tpu_pkg.sv
// Shared widths and the feeder state encoding for the unified-buffer feeder slice.
package tpu_pkg;
    localparam int UB_ADDR_W    = 6;
    localparam int UB_DEPTH     = 64;
    localparam int ACC_W        = 32;
    localparam int ACT_W        = 16;
    localparam int MAX_ROWS     = 32;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN
    } feeder_state_t;
endpackage

// File: rtl/sat_narrow.sv
// Clamps a signed IN_W-bit word into the signed OUT_W-bit range.
module sat_narrow #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    localparam int TOP_W = IN_W - OUT_W + 1;

    // The value fits exactly when every bit from the narrow sign bit upward agrees.
    logic [TOP_W-1:0] top_bits;
    assign top_bits = din[IN_W-1:OUT_W-1];

    always_comb begin
        if ((&top_bits) || (~|top_bits)) begin
            dout = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/ub_feeder.sv
// Streams a two-column matrix out of the unified buffer and feeds it, saturated
// and diagonally skewed, into the first two rows of the systolic array.
module ub_feeder
    import tpu_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [UB_ADDR_W-1:0]        base_addr,
    input  logic [UB_ADDR_W-1:0]        num_rows,
    output logic                        rd_en,
    output logic [UB_ADDR_W-1:0]        rd_addr0,
    output logic [UB_ADDR_W-1:0]        rd_addr1,
    input  logic signed [ACC_W-1:0]     rd_data0,
    input  logic signed [ACC_W-1:0]     rd_data1,
    output logic signed [ACT_W-1:0]     a_in1,
    output logic signed [ACT_W-1:0]     a_in2,
    output logic                        valid,
    output logic                        busy,
    output logic                        done
);
    feeder_state_t        state_reg, state_next;
    logic [UB_ADDR_W-1:0] base_reg, base_next;
    logic [UB_ADDR_W-1:0] rows_reg, rows_next;
    logic [UB_ADDR_W-1:0] cnt_reg, cnt_next;
    logic                 zero_done_reg, zero_done_next;
    logic [UB_ADDR_W-1:0] clamped_rows;

    assign clamped_rows = (num_rows > UB_ADDR_W'(MAX_ROWS)) ? UB_ADDR_W'(MAX_ROWS) : num_rows;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            base_reg      <= '0;
            rows_reg      <= '0;
            cnt_reg       <= '0;
            zero_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            base_reg      <= base_next;
            rows_reg      <= rows_next;
            cnt_reg       <= cnt_next;
            zero_done_reg <= zero_done_next;
        end
    end

    // cnt_reg is the row index while streaming and the drain tick while draining.
    always_comb begin
        state_next     = state_reg;
        base_next      = base_reg;
        rows_next      = rows_reg;
        cnt_next       = cnt_reg;
        zero_done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (clamped_rows == '0) begin
                        zero_done_next = 1'b1;
                    end else begin
                        state_next = ST_STREAM;
                        base_next  = base_addr;
                        rows_next  = clamped_rows;
                        cnt_next   = '0;
                    end
                end
            end
            ST_STREAM: begin
                if (cnt_reg == rows_reg - UB_ADDR_W'(1)) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + UB_ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_reg == UB_ADDR_W'(DRAIN_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + UB_ADDR_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    logic                 streaming;
    logic [UB_ADDR_W-1:0] row_addr;

    assign streaming = (state_reg == ST_STREAM);
    assign row_addr  = base_reg + {cnt_reg[UB_ADDR_W-2:0], 1'b0};
    assign rd_en     = streaming;
    assign rd_addr0  = streaming ? row_addr : '0;
    assign rd_addr1  = streaming ? row_addr + UB_ADDR_W'(1) : '0;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = zero_done_reg
                     | ((state_reg == ST_DRAIN) && (cnt_reg == UB_ADDR_W'(DRAIN_CYCLES - 1)));

    logic signed [ACC_W-1:0] rd_word  [2];
    logic signed [ACT_W-1:0] sat_word [2];

    assign rd_word[0] = rd_data0;
    assign rd_word[1] = rd_data1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            sat_narrow #(
                .IN_W  (ACC_W),
                .OUT_W (ACT_W)
            ) u_sat (
                .din  (rd_word[gi]),
                .dout (sat_word[gi])
            );
        end
    endgenerate

    // Column 1 passes through one extra stage so row r reaches lane 2 a cycle after lane 1.
    logic                    rd_v_reg;
    logic                    lane1_v_reg, skew_v_reg, lane2_v_reg;
    logic signed [ACT_W-1:0] lane1_reg, skew_reg, lane2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v_reg    <= 1'b0;
            lane1_v_reg <= 1'b0;
            skew_v_reg  <= 1'b0;
            lane2_v_reg <= 1'b0;
            lane1_reg   <= '0;
            skew_reg    <= '0;
            lane2_reg   <= '0;
        end else begin
            rd_v_reg    <= rd_en;
            lane1_v_reg <= rd_v_reg;
            skew_v_reg  <= rd_v_reg;
            lane2_v_reg <= skew_v_reg;
            lane1_reg   <= rd_v_reg ? sat_word[0] : '0;
            skew_reg    <= rd_v_reg ? sat_word[1] : '0;
            lane2_reg   <= skew_v_reg ? skew_reg : '0;
        end
    end

    assign a_in1 = lane1_reg;
    assign a_in2 = lane2_reg;
    assign valid = lane1_v_reg | lane2_v_reg;
endmodule

// File: tb/tb_ub_feeder.sv
// Directed bench for ub_feeder: a behavioural unified buffer answers reads one
// cycle later, and every output is compared each cycle against hand-derived timing.
module tb_ub_feeder;
    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [5:0]         base_addr;
    logic [5:0]         num_rows;
    logic               rd_en;
    logic [5:0]         rd_addr0, rd_addr1;
    logic signed [31:0] rd_data0, rd_data1;
    logic signed [15:0] a_in1, a_in2;
    logic               valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int mem [64];

    always #5 clk = ~clk;

    ub_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .rd_en     (rd_en),
        .rd_addr0  (rd_addr0),
        .rd_addr1  (rd_addr1),
        .rd_data0  (rd_data0),
        .rd_data1  (rd_data1),
        .a_in1     (a_in1),
        .a_in2     (a_in2),
        .valid     (valid),
        .busy      (busy),
        .done      (done)
    );

    // Garbage when not reading, so a lane that should be empty cannot pass by luck.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= mem[rd_addr0];
            rd_data1 <= mem[rd_addr1];
        end else begin
            rd_data0 <= 32'h7EAD_BEEF;
            rd_data1 <= 32'h7EAD_BEEF;
        end
    end

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at posedge+1; cycle 0 carries the start pulse. Later cycles scramble
    // base/num_rows to confirm they were latched. restart_c re-pulses start while
    // busy; reset_c pulses reset in that cycle; back2back ends right after done.
    task automatic run_stream(input int tno, input int base, input int nrows,
                              input int restart_c, input int reset_c, input bit back2back);
        int    ne, lastc;
        int    e_rd, e_a0, e_a1, e_in1, e_in2, e_valid, e_busy, e_done;
        bit    live;
        string pfx;
        ne    = (nrows > 32) ? 32 : nrows;
        lastc = back2back ? ((ne == 0) ? 1 : ne + 3) : ne + 5;
        for (int c = 0; c <= lastc; c++) begin
            live    = !(reset_c >= 0 && c > reset_c);
            e_rd    = (live && c >= 1 && c <= ne) ? 1 : 0;
            e_a0    = (e_rd != 0) ? (base + 2 * (c - 1)) % 64 : 0;
            e_a1    = (e_rd != 0) ? (base + 2 * (c - 1) + 1) % 64 : 0;
            e_in1   = (live && c >= 3 && c <= ne + 2) ? sat16(mem[(base + 2 * (c - 3)) % 64]) : 0;
            e_in2   = (live && c >= 4 && c <= ne + 3) ? sat16(mem[(base + 2 * (c - 4) + 1) % 64]) : 0;
            e_valid = (live && ne > 0 && c >= 3 && c <= ne + 3) ? 1 : 0;
            e_busy  = (live && ne > 0 && c >= 1 && c <= ne + 3) ? 1 : 0;
            e_done  = (live && ((ne > 0 && c == ne + 3) || (ne == 0 && c == 1))) ? 1 : 0;
            pfx = $sformatf("t%0d c%0d", tno, c);
            check_eq({pfx, " rd_en"},    rd_en,    e_rd);
            check_eq({pfx, " rd_addr0"}, rd_addr0, e_a0);
            check_eq({pfx, " rd_addr1"}, rd_addr1, e_a1);
            check_eq({pfx, " a_in1"},    a_in1,    e_in1);
            check_eq({pfx, " a_in2"},    a_in2,    e_in2);
            check_eq({pfx, " valid"},    valid,    e_valid);
            check_eq({pfx, " busy"},     busy,     e_busy);
            check_eq({pfx, " done"},     done,     e_done);
            reset = (c == reset_c);
            start = (c == 0) || (c == restart_c);
            if (c == 0) begin
                base_addr = 6'(base);
                num_rows  = 6'(nrows);
            end else begin
                base_addr = 6'($urandom);
                num_rows  = 6'($urandom_range(0, 63));
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b0;
        $display("[TB] stream %0d: base=%0d rows=%0d restart=%0d reset=%0d checked through cycle %0d",
                 tno, base, nrows, restart_c, reset_c, lastc);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = i * 1237 - 30000;
        mem[0]  = 1;      mem[1]  = 2;      mem[2]  = 3;      mem[3]  = 4;
        mem[10] = 40000;  mem[11] = -70000; mem[12] = 100;    mem[13] = -100;
        mem[14] = -32768; mem[15] = 32768;  mem[62] = -5;     mem[63] = 7;

        reset     = 1'b1;
        start     = 1'b1;
        base_addr = 6'd9;
        num_rows  = 6'd5;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset rd_en", rd_en, 0);
        check_eq("reset rd_addr0", rd_addr0, 0);
        check_eq("reset rd_addr1", rd_addr1, 0);
        check_eq("reset a_in1", a_in1, 0);
        check_eq("reset a_in2", a_in2, 0);
        check_eq("reset valid", valid, 0);
        check_eq("reset busy", busy, 0);
        check_eq("reset done", done, 0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;

        run_stream(1, 0, 2, -1, -1, 1'b0);   // {1,2,3,4} basic timing
        run_stream(2, 10, 3, -1, -1, 1'b0);  // saturation both directions and pass-through
        run_stream(3, 62, 2, -1, -1, 1'b0);  // address wrap 63 -> 0
        run_stream(4, 20, 3, 2, -1, 1'b0);   // second start while busy is ignored
        run_stream(5, 30, 4, -1, 3, 1'b0);   // reset mid-stream aborts silently
        run_stream(6, 4, 3, -1, -1, 1'b0);   // normal stream after the abort
        run_stream(7, 0, 0, -1, -1, 1'b0);   // zero rows: done only
        run_stream(8, 5, 40, -1, -1, 1'b1);  // clamped to 32, next start right after done
        run_stream(9, 50, 1, -1, -1, 1'b0);
        run_stream(10, 12, 2, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
